// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - decoder-side handshake/field bus and committed-frame outputs of frame_sequencer
interface frame_sequencer_if;
  logic        tx_begin;
  logic        bit_strobe;
  logic [31:0] preamble;
  logic [31:0] constant;
  logic [31:0] thermostat_id;
  logic [15:0] room_temp;
  logic [15:0] set_temp;
  logic [7:0]  state;

  logic        decode_clr;
  logic        busy;
  logic        frame_valid;
  logic        frame_error;
  logic [1:0]  err_code;
  logic [31:0] q_id;
  logic [15:0] q_room;
  logic [15:0] q_set;
  logic [7:0]  q_state;
  logic [7:0]  frame_count;

  modport master (
    output tx_begin, bit_strobe, preamble, constant, thermostat_id, room_temp, set_temp, state,
    input  decode_clr, busy, frame_valid, frame_error, err_code,
           q_id, q_room, q_set, q_state, frame_count
  );

  modport slave (
    input  tx_begin, bit_strobe, preamble, constant, thermostat_id, room_temp, set_temp, state,
    output decode_clr, busy, frame_valid, frame_error, err_code,
           q_id, q_room, q_set, q_state, frame_count
  );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame sequencer: clear, count strobes, validate, commit to shadow regs
// Optional inter-strobe timeout in RECEIVE enabled by defining FRAME_TIMEOUT_EN.
module frame_sequencer #(
  parameter int unsigned FRAME_BITS     = 192,
  parameter logic [31:0] EXP_PREAMBLE   = 32'hAAAA_AAAA,
  parameter logic [31:0] EXP_CONSTANT   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             rst_n,
  frame_sequencer_if.slave bus
);

  if (FRAME_BITS < 8 || FRAME_BITS > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("frame_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RECEIVE = 3'd2,
    S_CHECK   = 3'd3,
    S_COMMIT  = 3'd4
  } state_e;

  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

  state_e      state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic        ev_commit, ev_restart, ev_mismatch, ev_timeout;
  logic        frame_valid_q, frame_error_q;
  logic [1:0]  err_code_q;
  logic [31:0] q_id_q;
  logic [15:0] q_room_q, q_set_q;
  logic [7:0]  q_state_q, frame_count_q;
  logic        fields_ok;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Error is registered, so detect one cycle early to pulse on the final idle cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign fields_ok = (bus.preamble == EXP_PREAMBLE) && (bus.constant == EXP_CONSTANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ev_commit   = 1'b0;
    ev_restart  = 1'b0;
    ev_mismatch = 1'b0;
    ev_timeout  = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_begin) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bit_cnt_d = 8'd0;
`ifdef FRAME_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        state_d   = S_RECEIVE;
      end
      S_RECEIVE: begin
        // Restart outranks both the final strobe and a timeout in the same cycle.
        if (bus.tx_begin) begin
          ev_restart = 1'b1;
          state_d    = S_CLEAR;
        end else if (bus.bit_strobe) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
`ifdef FRAME_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          if (bit_cnt_q == LAST_BIT) state_d = S_CHECK;
        end
`ifdef FRAME_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          ev_timeout = 1'b1;
          state_d    = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_CHECK: begin
        if (fields_ok) begin
          ev_commit = 1'b1;
          state_d   = S_COMMIT;
        end else begin
          ev_mismatch = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.decode_clr = 1'b0;
    bus.busy       = 1'b0;
    case (state_q)
      S_CLEAR:   begin bus.decode_clr = 1'b1; bus.busy = 1'b1; end
      S_RECEIVE: bus.busy = 1'b1;
      S_CHECK:   bus.busy = 1'b1;
      default:   ;
    endcase
  end

  // Shadows load on the edge into COMMIT so frame_valid and q_* are seen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= 2'b00;
      q_id_q        <= 32'd0;
      q_room_q      <= 16'd0;
      q_set_q       <= 16'd0;
      q_state_q     <= 8'd0;
      frame_count_q <= 8'd0;
    end else begin
      frame_valid_q <= ev_commit;
      frame_error_q <= ev_restart | ev_mismatch | ev_timeout;
      if (ev_commit) begin
        q_id_q        <= bus.thermostat_id;
        q_room_q      <= bus.room_temp;
        q_set_q       <= bus.set_temp;
        q_state_q     <= bus.state;
        frame_count_q <= frame_count_q + 8'd1;
        err_code_q    <= 2'b00;
      end else if (ev_restart) begin
        err_code_q <= 2'b11;
      end else if (ev_mismatch) begin
        err_code_q <= 2'b10;
      end else if (ev_timeout) begin
        err_code_q <= 2'b01;
      end
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.err_code    = err_code_q;
  assign bus.q_id        = q_id_q;
  assign bus.q_room      = q_room_q;
  assign bus.q_set       = q_set_q;
  assign bus.q_state     = q_state_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
module tb_frame_sequencer;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 50000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_sequencer_if bus();

  frame_sequencer #(
    .FRAME_BITS    (192),
    .EXP_PREAMBLE  (32'hAAAA_AAAA),
    .EXP_CONSTANT  (32'h0000_0000),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [31:0] pre, input logic [31:0] id, input logic [15:0] room);
    bus.preamble      = pre;
    bus.constant      = 32'h0000_0000;
    bus.thermostat_id = id;
    bus.room_temp     = room;
    bus.set_temp      = 16'h00B4;
    bus.state         = 8'h03;
  endtask

  task automatic begin_frame();
    bus.tx_begin = 1'b1;
    cyc();
    bus.tx_begin = 1'b0;
    cyc();
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.bit_strobe = 1'b1;
      cyc();
      bus.bit_strobe = 1'b0;
      for (int j = 1; j < gap; j++) cyc();
    end
  endtask

  // Leaves the bench in the cycle two after the final strobe.
  task automatic final_strobe();
    bus.bit_strobe = 1'b1;
    cyc();
    bus.bit_strobe = 1'b0;
    cyc();
  endtask

  task automatic full_frame(input int gap);
    begin_frame();
    strobes(191, gap);
    final_strobe();
  endtask

  initial begin
    bus.tx_begin   = 1'b0;
    bus.bit_strobe = 1'b0;
    set_fields(32'hAAAA_AAAA, 32'hDEAD_BEEF, 16'h00C8);
    repeat (2) cyc();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_count", {24'd0, bus.frame_count}, 32'd0);
    check("rst_q_id", bus.q_id, 32'd0);
    rst_n = 1'b1;
    cyc();

    bus.tx_begin = 1'b1;
    cyc();
    bus.tx_begin = 1'b0;
    check("t1_clr_on", {31'd0, bus.decode_clr}, 32'd1);
    check("t1_busy_clear", {31'd0, bus.busy}, 32'd1);
    cyc();
    check("t1_clr_off", {31'd0, bus.decode_clr}, 32'd0);
    strobes(191, 4);
    bus.bit_strobe = 1'b1;
    cyc();
    bus.bit_strobe = 1'b0;
    check("t1_valid_early", {31'd0, bus.frame_valid}, 32'd0);
    cyc();
    check("t1_valid", {31'd0, bus.frame_valid}, 32'd1);
    check("t1_q_id", bus.q_id, 32'hDEAD_BEEF);
    check("t1_q_room", {16'd0, bus.q_room}, 32'h0000_00C8);
    check("t1_count", {24'd0, bus.frame_count}, 32'd1);
    check("t1_err", {30'd0, bus.err_code}, 32'd0);
    check("t1_no_error", {31'd0, bus.frame_error}, 32'd0);
    cyc();
    check("t1_valid_pulse", {31'd0, bus.frame_valid}, 32'd0);
    check("t1_busy_idle", {31'd0, bus.busy}, 32'd0);

    set_fields(32'hAAAA_AAAB, 32'h1234_5678, 16'h0011);
    full_frame(2);
    check("t2_error", {31'd0, bus.frame_error}, 32'd1);
    check("t2_err_code", {30'd0, bus.err_code}, 32'd2);
    check("t2_no_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("t2_q_id_kept", bus.q_id, 32'hDEAD_BEEF);
    check("t2_count_kept", {24'd0, bus.frame_count}, 32'd1);
    cyc();
    check("t2_error_pulse", {31'd0, bus.frame_error}, 32'd0);
    check("t2_err_held", {30'd0, bus.err_code}, 32'd2);

    set_fields(32'hAAAA_AAAA, 32'hCAFE_F00D, 16'h0123);
    begin_frame();
    strobes(100, 2);
    bus.tx_begin = 1'b1;
    cyc();
    bus.tx_begin = 1'b0;
    check("t3_restart_err", {31'd0, bus.frame_error}, 32'd1);
    check("t3_restart_code", {30'd0, bus.err_code}, 32'd3);
    check("t3_restart_clr", {31'd0, bus.decode_clr}, 32'd1);
    cyc();
    strobes(191, 2);
    check("t3_still_busy", {31'd0, bus.busy}, 32'd1);
    check("t3_no_early_valid", {24'd0, bus.frame_count}, 32'd1);
    final_strobe();
    check("t3_valid", {31'd0, bus.frame_valid}, 32'd1);
    check("t3_q_id", bus.q_id, 32'hCAFE_F00D);
    check("t3_q_room", {16'd0, bus.q_room}, 32'h0000_0123);
    check("t3_err_cleared", {30'd0, bus.err_code}, 32'd0);
    check("t3_count", {24'd0, bus.frame_count}, 32'd2);
    cyc();

    begin_frame();
    strobes(50, 1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_count", {24'd0, bus.frame_count}, 32'd0);
    check("t5_q_id", bus.q_id, 32'd0);
    check("t5_err", {30'd0, bus.err_code}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    full_frame(1);
    check("t5_valid", {31'd0, bus.frame_valid}, 32'd1);
    check("t5_count_after", {24'd0, bus.frame_count}, 32'd1);
    check("t5_q_id_after", bus.q_id, 32'hCAFE_F00D);
    cyc();
    exp_count = 8'd1;

    strobes(10, 1);
    check("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_idle_count", {24'd0, bus.frame_count}, {24'd0, exp_count});

    for (int i = 0; i < 255; i++) begin
      full_frame(1);
      exp_count = exp_count + 8'd1;
      if (exp_count == 8'd0) check("t6_wrap_zero", {24'd0, bus.frame_count}, 32'd0);
      cyc();
    end
    check("t6_wrap_end", {24'd0, bus.frame_count}, {24'd0, exp_count});

    begin_frame();
    strobes(50, 1);
`ifdef FRAME_TIMEOUT_EN
    repeat (18) cyc();
    check("t4_no_early_timeout", {31'd0, bus.frame_error}, 32'd0);
    cyc();
    check("t4_timeout_error", {31'd0, bus.frame_error}, 32'd1);
    check("t4_timeout_code", {30'd0, bus.err_code}, 32'd1);
    check("t4_timeout_busy", {31'd0, bus.busy}, 32'd0);
`else
    repeat (30) cyc();
    check("t4_still_busy", {31'd0, bus.busy}, 32'd1);
    check("t4_no_error", {31'd0, bus.frame_error}, 32'd0);
    bus.tx_begin = 1'b1;
    cyc();
    bus.tx_begin = 1'b0;
    check("t4_restart_code", {30'd0, bus.err_code}, 32'd3);
`endif
    check("t4_count_kept", {24'd0, bus.frame_count}, {24'd0, exp_count});
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
